// File: rtl/raster_pkg.sv
// Shared widths, coordinate/coefficient types and scan FSM encoding for bb_raster_scan.
package raster_pkg;

  localparam int unsigned XW       = 9;
  localparam int unsigned YW       = 8;
  localparam int unsigned CW       = 10;
  localparam int unsigned KW       = 20;
  localparam int unsigned EW       = 22;
  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;

  typedef logic        [XW-1:0] coord_x_t;
  typedef logic        [YW-1:0] coord_y_t;
  typedef logic signed [CW-1:0] coef_t;
  typedef logic signed [KW-1:0] const_t;
  typedef logic signed [EW-1:0] edge_acc_t;

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} scan_state_t;

  localparam coord_x_t XMax = coord_x_t'(SCREEN_W - 1);
  localparam coord_y_t YMax = coord_y_t'(SCREEN_H - 1);

  // Edge function at the box origin; coordinates zero-extend, coefficients sign-extend.
  function automatic edge_acc_t edge_init(input coef_t a, input coef_t b, input const_t c,
                                          input coord_x_t x, input coord_y_t y);
    return edge_acc_t'(a) * edge_acc_t'(x) + edge_acc_t'(b) * edge_acc_t'(y) + edge_acc_t'(c);
  endfunction

endpackage

// File: rtl/edge_step.sv
// One edge-function accumulator pair (row start, running column) with its inside test.
// Build option TOP_LEFT_EN applies the top-left fill rule to pixels lying exactly on the edge.
module edge_step
  import raster_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_step_x,
  input  logic                 i_step_y,
  input  logic signed [EW-1:0] i_init,
  input  logic signed [CW-1:0] i_a,
  input  logic signed [CW-1:0] i_b,
  output logic                 o_inside
);

  edge_acc_t r_row;
  edge_acc_t r_col;
  edge_acc_t w_row_next;
  logic      w_on_edge_ok;

  assign w_row_next = r_row + edge_acc_t'(i_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_load) begin
      r_row <= i_init;
      r_col <= i_init;
    end else if (i_step_y) begin
      r_row <= w_row_next;
      r_col <= w_row_next;
    end else if (i_step_x) begin
      r_col <= r_col + edge_acc_t'(i_a);
    end
  end

`ifdef TOP_LEFT_EN
  assign w_on_edge_ok = (!i_a[CW-1] && (i_a != '0)) ||
                        ((i_a == '0) && !i_b[CW-1] && (i_b != '0));
`else
  assign w_on_edge_ok = 1'b1;
`endif

  assign o_inside = !r_col[EW-1] && ((r_col != '0) || w_on_edge_ok);

endmodule

// File: rtl/bb_raster_scan.sv
// Bounding-box raster scanner: walks the clamped box row-major and emits covered pixels.
// Build option TOP_LEFT_EN (see edge_step) selects the top-left fill rule.
module bb_raster_scan
  import raster_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tri_valid,
  output logic                 tri_ready,
  input  logic signed [CW-1:0] a1,
  input  logic signed [CW-1:0] b1,
  input  logic signed [CW-1:0] a2,
  input  logic signed [CW-1:0] b2,
  input  logic signed [CW-1:0] a3,
  input  logic signed [CW-1:0] b3,
  input  logic signed [KW-1:0] c1,
  input  logic signed [KW-1:0] c2,
  input  logic signed [KW-1:0] c3,
  input  logic        [XW-1:0] bbxi,
  input  logic        [XW-1:0] bbxf,
  input  logic        [YW-1:0] bbyi,
  input  logic        [YW-1:0] bbyf,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic        [XW-1:0] pix_x,
  output logic        [YW-1:0] pix_y,
  output logic                 tri_done
);

  scan_state_t r_state, w_state_d;
  coef_t       r_a [3];
  coef_t       r_b [3];
  const_t      r_c [3];
  coord_x_t    r_bbxi, r_bbxf, r_xf, r_x, r_pix_x;
  coord_y_t    r_bbyi, r_bbyf, r_yf, r_y, r_pix_y;
  logic        r_scan_end, r_pix_valid;

  coord_x_t    w_xf;
  coord_y_t    w_yf;
  logic        w_accept, w_setup, w_degen, w_stall, w_eval, w_last_x, w_last, w_covered;
  logic [2:0]  w_inside;
  edge_acc_t   w_init [3];

  assign w_accept  = tri_valid && (r_state == IDLE);
  assign w_setup   = (r_state == SETUP);
  assign w_xf      = (r_bbxf > XMax) ? XMax : r_bbxf;
  assign w_yf      = (r_bbyf > YMax) ? YMax : r_bbyf;
  assign w_degen   = (r_bbxi > w_xf) || (r_bbyi > w_yf);
  assign w_stall   = r_pix_valid && !pix_ready;
  // r_scan_end marks (xf,yf) already evaluated; only the output drain remains.
  assign w_eval    = (r_state == SCAN) && !r_scan_end && !w_stall;
  assign w_last_x  = (r_x == r_xf);
  assign w_last    = w_last_x && (r_y == r_yf);
  assign w_covered = &w_inside;

  for (genvar i = 0; i < 3; i++) begin : g_edge
    assign w_init[i] = edge_init(r_a[i], r_b[i], r_c[i], r_bbxi, r_bbyi);

    edge_step u_edge_step (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_setup),
      .i_step_x (w_eval && !w_last_x),
      .i_step_y (w_eval && w_last_x && !w_last),
      .i_init   (w_init[i]),
      .i_a      (r_a[i]),
      .i_b      (r_b[i]),
      .o_inside (w_inside[i])
    );
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (tri_valid) w_state_d = SETUP;
      SETUP:   w_state_d = w_degen ? DONE : SCAN;
      SCAN:    if (r_scan_end && !w_stall) w_state_d = DONE;
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      for (int i = 0; i < 3; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
        r_c[i] <= '0;
      end
      r_bbxi      <= '0;
      r_bbxf      <= '0;
      r_bbyi      <= '0;
      r_bbyf      <= '0;
      r_xf        <= '0;
      r_yf        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_scan_end  <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_a[0] <= a1;
        r_b[0] <= b1;
        r_c[0] <= c1;
        r_a[1] <= a2;
        r_b[1] <= b2;
        r_c[1] <= c2;
        r_a[2] <= a3;
        r_b[2] <= b3;
        r_c[2] <= c3;
        r_bbxi <= bbxi;
        r_bbxf <= bbxf;
        r_bbyi <= bbyi;
        r_bbyf <= bbyf;
      end
      if (w_setup) begin
        r_xf       <= w_xf;
        r_yf       <= w_yf;
        r_x        <= r_bbxi;
        r_y        <= r_bbyi;
        r_scan_end <= 1'b0;
      end
      if (w_eval) begin
        if (w_last) begin
          r_scan_end <= 1'b1;
        end else if (w_last_x) begin
          r_x <= r_bbxi;
          r_y <= r_y + coord_y_t'(1);
        end else begin
          r_x <= r_x + coord_x_t'(1);
        end
      end
      if (w_eval) begin
        r_pix_valid <= w_covered;
        if (w_covered) begin
          r_pix_x <= r_x;
          r_pix_y <= r_y;
        end
      end else if (pix_ready) begin
        r_pix_valid <= 1'b0;
      end
    end
  end

  assign tri_ready = (r_state == IDLE);
  assign tri_done  = (r_state == DONE);
  assign pix_valid = r_pix_valid;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;

endmodule

// File: tb/tb_bb_raster_scan.sv
// Randomised self-checking bench for bb_raster_scan against a per-pixel edge-function model.
module tb_bb_raster_scan;

  logic              clk = 1'b0;
  logic              rst;
  logic              tri_valid;
  logic              tri_ready;
  logic signed [9:0] a1, b1, a2, b2, a3, b3;
  logic signed [19:0] c1, c2, c3;
  logic [8:0]        bbxi, bbxf;
  logic [7:0]        bbyi, bbyf;
  logic              pix_valid;
  logic              pix_ready;
  logic [8:0]        pix_x;
  logic [7:0]        pix_y;
  logic              tri_done;

  int checks = 0;
  int errors = 0;

  int t_a [3];
  int t_b [3];
  int t_c [3];
  int t_xi, t_xf, t_yi, t_yf;

  int exp_x[$];
  int exp_y[$];
  int got_x[$];
  int got_y[$];
  int acc_wait, first_pv_cycle, done_cycle, stall_errs;
  bit timed_out;

  always #5 clk = ~clk;

  bb_raster_scan dut (
    .clk       (clk),
    .rst       (rst),
    .tri_valid (tri_valid),
    .tri_ready (tri_ready),
    .a1        (a1),
    .b1        (b1),
    .a2        (a2),
    .b2        (b2),
    .a3        (a3),
    .b3        (b3),
    .c1        (c1),
    .c2        (c2),
    .c3        (c3),
    .bbxi      (bbxi),
    .bbxf      (bbxf),
    .bbyi      (bbyi),
    .bbyf      (bbyf),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .tri_done  (tri_done)
  );

  function automatic bit edge_in(input int e, input int a, input int b);
`ifdef TOP_LEFT_EN
    if (e > 0) return 1'b1;
    if (e == 0) return (a > 0) || (a == 0 && b > 0);
    return 1'b0;
`else
    return e >= 0;
`endif
  endfunction

  // Reference: visit the clamped box in raster order and evaluate each edge directly.
  task automatic build_expected();
    int xf, yf;
    bit ok;
    exp_x.delete();
    exp_y.delete();
    xf = (t_xf > 319) ? 319 : t_xf;
    yf = (t_yf > 239) ? 239 : t_yf;
    for (int y = t_yi; y <= yf; y++) begin
      for (int x = t_xi; x <= xf; x++) begin
        ok = 1'b1;
        for (int k = 0; k < 3; k++)
          if (!edge_in(t_a[k] * x + t_b[k] * y + t_c[k], t_a[k], t_b[k])) ok = 1'b0;
        if (ok) begin
          exp_x.push_back(x);
          exp_y.push_back(y);
        end
      end
    end
  endtask

  task automatic set_tri1();
    t_a[0] = 0;  t_b[0] = 4;  t_c[0] = 0;
    t_a[1] = -4; t_b[1] = -4; t_c[1] = 16;
    t_a[2] = 4;  t_b[2] = 0;  t_c[2] = 0;
    t_xi = 0; t_xf = 4; t_yi = 0; t_yf = 4;
  endtask

  task automatic set_random_tri();
    for (int k = 0; k < 3; k++) begin
      t_a[k] = int'($urandom_range(0, 1022)) - 511;
      t_b[k] = int'($urandom_range(0, 1022)) - 511;
      t_c[k] = int'($urandom_range(0, 300000)) - 150000;
    end
    t_xi = int'($urandom_range(0, 335));
    t_xf = t_xi + int'($urandom_range(0, 14)) - (($urandom_range(0, 7) == 0) ? 16 : 0);
    if (t_xf < 0) t_xf = 0;
    t_yi = int'($urandom_range(0, 245));
    t_yf = t_yi + int'($urandom_range(0, 6));
  endtask

  // Drives the current triangle, then collects transfers until tri_done (or stop_after pixels).
  // Cycle 1 is the first sample after the accepting edge.
  task automatic run_scan(input int mode, input int stop_after, input bit keep_valid);
    int cyc, ph;
    bit hold, fin;
    logic [8:0] hx;
    logic [7:0] hy;
    got_x.delete();
    got_y.delete();
    stall_errs = 0; timed_out = 1'b0; first_pv_cycle = -1; done_cycle = -1; acc_wait = 0;
    a1 = 10'(t_a[0]); b1 = 10'(t_b[0]); c1 = 20'(t_c[0]);
    a2 = 10'(t_a[1]); b2 = 10'(t_b[1]); c2 = 20'(t_c[1]);
    a3 = 10'(t_a[2]); b3 = 10'(t_b[2]); c3 = 20'(t_c[2]);
    bbxi = 9'(t_xi); bbxf = 9'(t_xf); bbyi = 8'(t_yi); bbyf = 8'(t_yf);
    tri_valid = 1'b1;
    while (tri_ready !== 1'b1 && acc_wait < 20) begin
      @(posedge clk); #1;
      acc_wait++;
    end
    if (tri_ready !== 1'b1) begin
      tri_valid = 1'b0;
      timed_out = 1'b1;
      return;
    end
    @(posedge clk); #1;
    if (!keep_valid) begin
      tri_valid = 1'b0;
      a1 = 10'($urandom); b1 = 10'($urandom); c1 = 20'($urandom);
      a2 = 10'($urandom); b2 = 10'($urandom); c2 = 20'($urandom);
      a3 = 10'($urandom); b3 = 10'($urandom); c3 = 20'($urandom);
      bbxi = 9'($urandom); bbxf = 9'($urandom); bbyi = 8'($urandom); bbyf = 8'($urandom);
    end
    cyc = 1; ph = 0; hold = 1'b0; fin = 1'b0; hx = '0; hy = '0;
    while (!fin && cyc < 5000) begin
      if (hold && (pix_valid !== 1'b1 || pix_x !== hx || pix_y !== hy)) stall_errs++;
      if (tri_done === 1'b1) begin
        done_cycle = cyc;
        fin = 1'b1;
      end else begin
        case (mode)
          0:       pix_ready = 1'b1;
          1:       pix_ready = (ph % 4 == 0) || (ph % 4 == 3);
          default: pix_ready = 1'($urandom_range(0, 1));
        endcase
        ph++;
        if (pix_valid === 1'b1 && first_pv_cycle < 0) first_pv_cycle = cyc;
        hold = (pix_valid === 1'b1) && !pix_ready;
        hx = pix_x;
        hy = pix_y;
        if (pix_valid === 1'b1 && pix_ready) begin
          got_x.push_back(int'(pix_x));
          got_y.push_back(int'(pix_y));
        end
        @(posedge clk); #1;
        cyc++;
        if (stop_after > 0 && got_x.size() >= stop_after) fin = 1'b1;
      end
    end
    if (!fin) timed_out = 1'b1;
    pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tri_valid = 1'b0; pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tri_ready !== 1'b1) begin errors++; $display("FAIL reset_tri_ready: got %b want 1", tri_ready); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
    checks++; if (pix_x !== 9'd0) begin errors++; $display("FAIL reset_pix_x: got %0d want 0", pix_x); end
    checks++; if (pix_y !== 8'd0) begin errors++; $display("FAIL reset_pix_y: got %0d want 0", pix_y); end
    checks++; if (tri_done !== 1'b0) begin errors++; $display("FAIL reset_tri_done: got %b want 0", tri_done); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (tri_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", tri_ready); end
  endtask

  task automatic test_basic();
    int want_n;
`ifdef TOP_LEFT_EN
    want_n = 10;
`else
    want_n = 15;
`endif
    set_tri1();
    build_expected();
    run_scan(0, 0, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got timeout want tri_done"); end
    checks++; if (got_x.size() != want_n) begin errors++; $display("FAIL basic_count: got %0d want %0d", got_x.size(), want_n); end
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
      checks++;
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
        errors++;
        $display("FAIL basic_pix[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
      end
    end
    checks++; if (first_pv_cycle != 3) begin errors++; $display("FAIL basic_latency: got cycle %0d want 3", first_pv_cycle); end
    @(posedge clk); #1;
    checks++; if (tri_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", tri_done); end
    checks++; if (tri_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b want 1", tri_ready); end
  endtask

  task automatic test_stall();
    set_tri1();
    build_expected();
    run_scan(1, 0, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout: got timeout want tri_done"); end
    checks++; if (got_x.size() != exp_x.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", got_x.size(), exp_x.size()); end
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
      checks++;
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
        errors++;
        $display("FAIL stall_pix[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
      end
    end
    checks++; if (stall_errs != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_errs); end
  endtask

  task automatic test_degenerate();
    set_tri1();
    t_xi = 10; t_xf = 5;
    run_scan(0, 0, 1'b0);
    checks++; if (first_pv_cycle != -1) begin errors++; $display("FAIL degen_no_pix: got pix_valid at %0d want none", first_pv_cycle); end
    checks++; if (done_cycle != 2) begin errors++; $display("FAIL degen_done_cycle: got %0d want 2", done_cycle); end
    @(posedge clk); #1;
    checks++; if (tri_ready !== 1'b1) begin errors++; $display("FAIL degen_ready: got %b want 1", tri_ready); end
  endtask

  task automatic test_clamp();
    int max_x;
    for (int k = 0; k < 3; k++) begin t_a[k] = 0; t_b[k] = 0; t_c[k] = 1; end
    t_xi = 300; t_xf = 400; t_yi = 5; t_yf = 7;
    build_expected();
    run_scan(0, 0, 1'b0);
    max_x = 0;
    foreach (got_x[i]) if (got_x[i] > max_x) max_x = got_x[i];
    checks++; if (got_x.size() != 60) begin errors++; $display("FAIL clamp_x_count: got %0d want 60", got_x.size()); end
    checks++; if (max_x != 319) begin errors++; $display("FAIL clamp_x_max: got %0d want 319", max_x); end
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
      checks++;
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
        errors++;
        $display("FAIL clamp_pix[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
      end
    end
    t_xi = 0; t_xf = 3; t_yi = 238; t_yf = 255;
    run_scan(0, 0, 1'b0);
    checks++; if (got_x.size() != 8) begin errors++; $display("FAIL clamp_y_count: got %0d want 8", got_x.size()); end
  endtask

  task automatic test_reset_mid();
    set_tri1();
    build_expected();
    run_scan(0, 5, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL midrst_pix_valid: got %b want 0", pix_valid); end
    checks++; if (tri_ready !== 1'b1) begin errors++; $display("FAIL midrst_tri_ready: got %b want 1", tri_ready); end
    checks++; if (pix_x !== 9'd0 || pix_y !== 8'd0) begin errors++; $display("FAIL midrst_pix_xy: got (%0d,%0d) want (0,0)", pix_x, pix_y); end
    @(posedge clk); #1;
    rst = 1'b0;
    run_scan(0, 0, 1'b0);
    checks++; if (got_x.size() != exp_x.size()) begin errors++; $display("FAIL midrst_count: got %0d want %0d", got_x.size(), exp_x.size()); end
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
      checks++;
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
        errors++;
        $display("FAIL midrst_pix[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_tri1();
    build_expected();
    run_scan(0, 0, 1'b1);
    checks++; if (got_x.size() != exp_x.size()) begin errors++; $display("FAIL b2b_first_count: got %0d want %0d", got_x.size(), exp_x.size()); end
    checks++; if (tri_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready: got %b want 0", tri_ready); end
    set_random_tri();
    t_xi = 20; t_xf = 27; t_yi = 30; t_yf = 33;
    build_expected();
    run_scan(0, 0, 1'b0);
    checks++; if (acc_wait != 1) begin errors++; $display("FAIL b2b_accept_gap: got %0d cycles want 1", acc_wait); end
    checks++; if (got_x.size() != exp_x.size()) begin errors++; $display("FAIL b2b_second_count: got %0d want %0d", got_x.size(), exp_x.size()); end
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
      checks++;
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
        errors++;
        $display("FAIL b2b_pix[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      set_random_tri();
      build_expected();
      run_scan(2, 0, 1'b0);
      checks++; if (timed_out) begin errors++; $display("FAIL rand%0d_timeout: got timeout want tri_done", n); end
      checks++; if (got_x.size() != exp_x.size()) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", n, got_x.size(), exp_x.size()); end
      for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
        checks++;
        if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
          errors++;
          $display("FAIL rand%0d_pix[%0d]: got (%0d,%0d) want (%0d,%0d)", n, i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
        end
      end
      checks++; if (stall_errs != 0) begin errors++; $display("FAIL rand%0d_hold: got %0d unstable cycles want 0", n, stall_errs); end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_degenerate();
    test_clamp();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
